// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl encoding, exec-unit FSM states and helpers.
// Imported by the ALU decoder, alu_comb_core and alu_exec_unit.
package alu_pkg;

  localparam int ALU_CTRL_W = 3;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_HOLD
  } alu_state_t;

  function automatic logic is_shift(input alu_ctrl_t ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Purely combinational ADD/SUB/AND/OR/SLT datapath.
// Any other code evaluates as ADD, matching the decoder default.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_ctrl_t        i_ctrl,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves o_y unassigned,
    // which would otherwise infer a latch.
    o_y = i_a + i_b;
    case (i_ctrl)
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_SLT: o_y = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_y = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes and a registered result/zero.
// Define ALU_SHIFT_EN to run codes 100/110/111 as serial SLL/SRL/SRA; otherwise they execute as ADD.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  zero
);

  alu_state_t       r_state;
  alu_state_t       w_next_state;
  alu_ctrl_t        w_ctrl;
  logic             w_accept;
  logic [WIDTH-1:0] w_core_y;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  assign w_ctrl    = alu_ctrl_t'(alu_ctrl);
  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
  assign out_valid = (r_state == ST_HOLD);
  assign w_accept  = in_valid && in_ready;
  assign result    = r_result;
  assign zero      = r_zero;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .i_ctrl (w_ctrl),
    .i_a    (src_a),
    .i_b    (src_b),
    .o_y    (w_core_y)
  );

`ifdef ALU_SHIFT_EN
  logic [SHAMT_W-1:0] w_shamt;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   w_shifted;
  alu_ctrl_t          r_op;
  logic               w_start_shift;

  assign w_shamt       = src_b[SHAMT_W-1:0];
  assign w_start_shift = is_shift(w_ctrl) && (w_shamt != '0);
  // A shift by zero completes on the accept edge and simply passes src_a through.
  assign w_load_val    = is_shift(w_ctrl) ? src_a : w_core_y;

  always_comb begin
    w_shifted = r_work << 1;
    case (r_op)
      ALU_SRL: w_shifted = r_work >> 1;
      ALU_SRA: w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_shifted = r_work << 1;
    endcase
  end
`else
  assign w_load_val = w_core_y;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (w_accept) begin
`ifdef ALU_SHIFT_EN
          w_next_state = w_start_shift ? ST_BUSY : ST_HOLD;
`else
          w_next_state = ST_HOLD;
`endif
        end else if ((r_state == ST_HOLD) && out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
`ifdef ALU_SHIFT_EN
      // The last shift step lands in the result register on the same edge.
      ST_BUSY: if (r_cnt == SHAMT_W'(1)) w_next_state = ST_HOLD;
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b1;
`ifdef ALU_SHIFT_EN
      r_cnt    <= '0;
      r_work   <= '0;
      r_op     <= ALU_ADD;
`endif
    end else if (w_accept) begin
`ifdef ALU_SHIFT_EN
      r_op <= w_ctrl;
      if (w_start_shift) begin
        r_work <= src_a;
        r_cnt  <= w_shamt;
      end else begin
        r_result <= w_load_val;
        r_zero   <= (w_load_val == '0);
      end
`else
      r_result <= w_load_val;
      r_zero   <= (w_load_val == '0);
`endif
    end
`ifdef ALU_SHIFT_EN
    else if (r_state == ST_BUSY) begin
      r_work <= w_shifted;
      r_cnt  <= r_cnt - SHAMT_W'(1);
      if (r_cnt == SHAMT_W'(1)) begin
        r_result <= w_shifted;
        r_zero   <= (w_shifted == '0);
      end
    end
`endif
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed handshake/boundary steps plus
// randomized operations checked against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic shifts_enabled();
`ifdef ALU_SHIFT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: result straight from the ISA meaning of each code.
  function automatic logic [W-1:0] ref_result(input logic [2:0] c, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int unsigned sh;
    logic signed [W-1:0] sa;
    sh = b % W;
    sa = a;
    case (c)
      3'b000: return a + b;
      3'b001: return a - b;
      3'b010: return a & b;
      3'b011: return a | b;
      3'b101: return (sa < $signed(b)) ? 1 : 0;
      3'b100: return shifts_enabled() ? a << sh : a + b;
      3'b110: return shifts_enabled() ? a >> sh : a + b;
      default: return shifts_enabled() ? W'(sa >>> sh) : a + b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] c, input logic [W-1:0] b);
    if (shifts_enabled() && (c == 3'b100 || c == 3'b110 || c == 3'b111))
      return int'(b % W) + 1;
    return 1;
  endfunction

  // Presents one op at a negedge, waits for acceptance, then waits for out_valid.
  task automatic run_op(input string tag, input logic [2:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int cycles;
    int leak;
    logic [W-1:0] exp;
    exp = ref_result(c, a, b);
    alu_ctrl = c; src_a = a; src_b = b; in_valid = 1'b1;
    cycles = 0;
    while (!in_ready && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    cycles = 0;
    leak = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!out_valid && in_ready) leak++;
    end while (!out_valid && cycles < 100);
    check({tag, "_latency"}, W'(cycles), W'(ref_latency(c, b)));
    check({tag, "_busy_ready"}, W'(leak), W'(0));
    check({tag, "_result"}, result, exp);
    check({tag, "_zero"}, W'(zero), W'(exp == '0));
  endtask

  initial begin
    logic [2:0]   rc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           stale;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_result", result, '0);
    check("rst_zero", W'(zero), W'(1));
    check("rst_in_ready", W'(in_ready), W'(1));

    // Wrap-around add and a zero-producing subtract.
    run_op("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
    run_op("sub_zero", 3'b001, 32'd5, 32'd5);
    run_op("slt_neg", 3'b101, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("slt_pos", 3'b101, 32'h0000_0001, 32'hFFFF_FFFF);

    // Back-to-back stream with in_valid held high.
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 3'b000; src_a = 32'd1; src_b = 32'd2;
    check("b2b_ready0", W'(in_ready), W'(1));
    @(posedge clk);
    #1 alu_ctrl = 3'b011; src_a = 32'hF0; src_b = 32'h0F;
    @(negedge clk);
    check("b2b_res0", result, 32'd3);
    check("b2b_ready1", W'(in_ready), W'(1));
    @(posedge clk);
    #1 alu_ctrl = 3'b010; src_a = 32'hFF; src_b = 32'h0F;
    @(negedge clk);
    check("b2b_res1", result, 32'hFF);
    check("b2b_ready2", W'(in_ready), W'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b_res2", result, 32'h0F);
    check("b2b_valid2", W'(out_valid), W'(1));
    @(negedge clk);
    check("b2b_drain", W'(out_valid), W'(0));

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    in_valid = 1'b1; alu_ctrl = 3'b000; src_a = 32'd10; src_b = 32'd20;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid", W'(out_valid), W'(1));
      check("bp_result", result, 32'd30);
      check("bp_in_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    in_valid = 1'b1; alu_ctrl = 3'b001; src_a = 32'd9; src_b = 32'd4;
    #1 check("bp_release_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_result", result, 32'd5);
    check("bp_next_valid", W'(out_valid), W'(1));

`ifdef ALU_SHIFT_EN
    run_op("sra_max", 3'b111, 32'h8000_0000, 32'd31);
    run_op("sll_zero", 3'b100, 32'hDEAD_BEEF, 32'd0);
    run_op("srl_4", 3'b110, 32'hF000_0000, 32'd4);

    // Reset in the middle of a long shift discards it.
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 3'b100; src_a = 32'd1; src_b = 32'd20;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
`else
    run_op("code100_add", 3'b100, 32'd2, 32'd3);
    run_op("code111_add", 3'b111, 32'hFFFF_FFFF, 32'd1);

    // Reset while a result is being held discards it.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 3'b000; src_a = 32'd7; src_b = 32'd8;
    @(posedge clk);
    #1 in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
`endif
    @(negedge clk);
    check("midrst_valid", W'(out_valid), W'(0));
    check("midrst_result", result, '0);
    check("midrst_zero", W'(zero), W'(1));
    check("midrst_ready", W'(in_ready), W'(1));
    stale = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst_no_stale", W'(stale), W'(0));

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      rc = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? ra : $urandom;
      run_op("rand", rc, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 3-bit ALUControl code produced by the ALU decoder, plus two operands, and returns a registered result and zero flag. Uses valid/ready handshakes on both input and output. Single-cycle ops (ADD/SUB/AND/OR/SLT) complete in one cycle. When ALU_SHIFT_EN is defined, the otherwise unused codes run as serial multi-cycle shifts. Sits between decode/operand-select and writeback/branch logic in the multi-cycle core.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of two, ≥ 8.
SHAMT_W, $clog2(WIDTH), shift-amount width taken from src_b LSBs.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
in_valid  input  1  operands and control valid
in_ready  output  1  unit can accept a new operation
alu_ctrl  input  3  ALUControl code
src_a  input  WIDTH  operand A
src_b  input  WIDTH  operand B (shift amount in [SHAMT_W-1:0])
out_valid  output  1  result/zero valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  registered (result == 0)

Behaviour:
- Encoding (fixed): 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT (signed), 100 SLL, 110 SRL, 111 SRA.
- ADD/SUB wrap modulo 2^WIDTH; no overflow/carry outputs. SLT result = {WIDTH-1 zeros, signed(src_a) < signed(src_b)}.
- FSM states: IDLE, BUSY, HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). out_valid = (state==HOLD).
- Accept = in_valid && in_ready. On accept, operands and code are captured.
- Single-cycle op, or shift with shamt==0: result/zero are loaded on the accept edge. Next state is HOLD. Latency is 1 cycle from accept to out_valid.
- Shift with shamt>0: a working register is loaded with src_a and a counter with shamt, then state goes to BUSY. Each BUSY cycle shifts by 1 bit and decrements the counter. SLL fills with 0, SRL fills with 0, SRA fills with the MSB. When the counter reaches 0, result/zero are loaded and state goes to HOLD. Latency is shamt+1 cycles. Maximum latency is WIDTH cycles (shamt=WIDTH-1).
- HOLD: result/zero stay stable until out_ready.
  - out_ready && !in_valid → IDLE.
  - out_ready && in_valid → accept the new op in the same cycle (back-to-back, 1 op/cycle for single-cycle ops).
- BUSY ignores in_valid (in_ready=0). out_ready is don't-care in IDLE and BUSY.
- Reset, including mid-BUSY: state=IDLE, out_valid=0, result=0, zero=1, counter=0. The in-flight operation is discarded.
- in_valid without in_ready: inputs are not sampled. The producer must hold inputs stable until accepted.

Optional Feature:
ALU_SHIFT_EN.
- Defined: codes 100/110/111 execute as serial SLL/SRL/SRA as above.
- Undefined: codes 100/110/111 execute as ADD with 1-cycle latency, matching the decoder default. The BUSY state and shift counter are not generated.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] alu_ctrl_t (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA);
  - typedef enum for FSM states;
  - localparam ALU_CTRL_W = 3.
- The ALU decoder imports the same enum.
- One sub-module, alu_comb_core: purely combinational ADD/SUB/AND/OR/SLT on WIDTH bits. It is instantiated once; its output feeds the result register.

Test Plan:
1. ADD 0x7FFFFFFF + 0x00000001 → after 1 cycle: out_valid=1, result=0x80000000, zero=0. SUB 5-5 → result=0, zero=1.
2. SLT src_a=0xFFFFFFFF (-1), src_b=0x00000001 → result=1. Swapped operands → result=0.
3. Back-to-back: in_valid held high, out_ready=1, sequence ADD 1+2, OR 0xF0|0x0F, AND 0xFF&0x0F → results 3, 0xFF, 0x0F on consecutive cycles. in_ready stays 1 throughout.
4. Backpressure: out_ready=0 for 4 cycles after an ADD result → result stable, out_valid=1, in_ready=0. Then out_ready=1 → transfer completes, new op accepted the same cycle.
5. (ALU_SHIFT_EN) SRA src_a=0x80000000, src_b=31 → in_ready=0 for 31 cycles, out_valid on cycle 32, result=0xFFFFFFFF. SLL by 0 → 1-cycle latency, result=src_a. Without the macro, code 100 with 2,3 → result=5 in 1 cycle.
6. Assert rst mid-BUSY (SLL by 20, reset at cycle 7) → next cycle: state IDLE, out_valid=0, result=0, zero=1, in_ready=1. No stale result appears afterward.
